// File: rtl/fetch_sequencer_pkg.sv
// Shared definitions for the instruction fetch sequencer: the fetch FSM
// state encoding, the PC increment and the wrapping next-PC helper.
package fetch_pkg;

    typedef enum logic [1:0] {
        FETCH = 2'd0,
        WAIT  = 2'd1,
        IDLE  = 2'd2
    } fetch_state_t;

    localparam logic [31:0] PC_STEP = 32'd4;

    // Next byte PC: advance one word and keep only the ADDR_W+2 bits that
    // address the ROM, so the last word wraps back to word 0.
    function automatic logic [31:0] next_pc(input logic [31:0] pc, input int addr_w);
        logic [31:0] mask;
        mask = (addr_w >= 30) ? 32'hFFFF_FFFF : ((32'd1 << (addr_w + 2)) - 32'd1);
        return (pc + PC_STEP) & mask;
    endfunction

endpackage

// File: rtl/fetch_sequencer_run_tick_gen.sv
// Run-mode divider: counts 0..RUN_DIV-1 while enabled and pulses tick on
// the last count; parked at 0 whenever Run mode is off.
module run_tick_gen #(
    parameter int RUN_DIV = 50000000
) (
    input  logic clock,
    input  logic reset,
    input  logic enable,
    output logic tick
);

    localparam int CNT_W = (RUN_DIV > 1) ? $clog2(RUN_DIV) : 1;
    localparam logic [CNT_W-1:0] LAST = CNT_W'(RUN_DIV - 1);

    logic [CNT_W-1:0] count;

    // Free-running divider that restarts from 0 each time Run is entered.
    always_ff @(posedge clock) begin
        if (reset || !enable) begin
            count <= '0;
        end else if (count == LAST) begin
            count <= '0;
        end else begin
            count <= count + 1'b1;
        end
    end

    assign tick = enable && (count == LAST);

endmodule

// File: rtl/fetch_sequencer.sv
// Instruction fetch sequencer for the single-cycle CPU lab board. Owns the
// PC, presents the ROM word address, waits out the ROM latency and latches
// the fetched word. The PC advances on a Step button edge or on Run-mode
// ticks. Optional breakpoint halting is built when FETCH_BRK_EN is defined.
module fetch_sequencer
    import fetch_pkg::*;
#(
    parameter int ADDR_W  = 6,
    parameter int MEM_LAT = 1,
    parameter int RUN_DIV = 50000000
) (
    input  logic              Clk,
    input  logic              Rst,
    input  logic              Step,
    input  logic              Run,
    input  logic [31:0]       Brk_pc,
    output logic [ADDR_W-1:0] Mem_addr,
    input  logic [31:0]       Mem_data,
    output logic [31:0]       PC,
    output logic [31:0]       Inst_code,
    output logic              Inst_valid,
    output logic              Halted
);

    localparam logic [1:0] LAT = 2'(MEM_LAT);

    fetch_state_t state;
    fetch_state_t state_next;
    logic [1:0]   wait_cnt;
    logic         step_q;
    logic         step_edge;
    logic         pending;
    logic         tick;
    logic         advance;
    logic         load_word;
    logic         brk_hit;

    run_tick_gen #(
        .RUN_DIV(RUN_DIV)
    ) u_run_tick (
        .clock (Clk),
        .reset (Rst),
        .enable(Run),
        .tick  (tick)
    );

    assign step_edge = Step && !step_q;
    assign Mem_addr  = PC[ADDR_W+1:2];

`ifdef FETCH_BRK_EN
    assign brk_hit = (state == IDLE) && Run && Inst_valid && (PC == Brk_pc);

    // Breakpoint latch: set on a match in Run mode, released by leaving Run.
    always_ff @(posedge Clk) begin
        if (Rst) begin
            Halted <= 1'b0;
        end else if (!Run) begin
            Halted <= 1'b0;
        end else if (brk_hit) begin
            Halted <= 1'b1;
        end
    end
`else
    logic unused_brk_pc;
    assign unused_brk_pc = ^Brk_pc;
    assign brk_hit       = 1'b0;
    assign Halted        = 1'b0;
`endif

    // FSM state register; reset restarts with a fetch of word 0.
    always_ff @(posedge Clk) begin
        if (Rst) begin
            state <= FETCH;
        end else begin
            state <= state_next;
        end
    end

    // Next-state and control decode. A match on the breakpoint blocks the
    // coincident tick too, so the PC never slips past the breakpoint.
    always_comb begin
        state_next = state;
        advance    = 1'b0;
        load_word  = 1'b0;
        case (state)
            FETCH: begin
                state_next = WAIT;
            end
            WAIT: begin
                if (wait_cnt == 2'd1) begin
                    load_word  = 1'b1;
                    state_next = IDLE;
                end
            end
            IDLE: begin
                if (Run) begin
                    advance = tick && !Halted && !brk_hit;
                end else begin
                    advance = step_edge || pending;
                end
                if (advance) begin
                    state_next = FETCH;
                end
            end
            default: begin
                state_next = FETCH;
            end
        endcase
    end

    // Datapath: PC, latency counter, fetched word, step edge history and
    // the one-deep step request held while a fetch is in flight.
    always_ff @(posedge Clk) begin
        if (Rst) begin
            PC         <= 32'd0;
            Inst_code  <= 32'd0;
            Inst_valid <= 1'b0;
            wait_cnt   <= 2'd0;
            step_q     <= 1'b0;
            pending    <= 1'b0;
        end else begin
            step_q <= Step;

            if (state == FETCH) begin
                wait_cnt   <= LAT;
                Inst_valid <= 1'b0;
            end else if (state == WAIT) begin
                wait_cnt <= wait_cnt - 2'd1;
            end

            if (load_word) begin
                Inst_code  <= Mem_data;
                Inst_valid <= 1'b1;
            end

            if (advance) begin
                PC         <= next_pc(PC, ADDR_W);
                Inst_valid <= 1'b0;
            end

            if (Run || advance) begin
                pending <= 1'b0;
            end else if (step_edge && (state != IDLE)) begin
                pending <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_fetch_sequencer.sv
// Self-checking bench for fetch_sequencer: randomized Step/Run/Rst stimulus,
// a transaction-level reference model that predicts PC and fetch timing from
// cycle arithmetic, and a scoreboard monitor that checks every completed
// fetch. Breakpoint scenarios are exercised when FETCH_BRK_EN is defined.
module tb_fetch_sequencer;

    localparam int ADDR_W  = 6;
    localparam int MEM_LAT = 1;
    localparam int RUN_DIV = 4;
    localparam int NWORDS  = 1 << ADDR_W;
    localparam logic [31:0] PC_SPAN = 32'(4 * NWORDS);

    typedef struct {
        logic [31:0] pc;
        logic [31:0] code;
    } fetch_t;

    logic              Clk    = 1'b0;
    logic              Rst    = 1'b1;
    logic              Step   = 1'b0;
    logic              Run    = 1'b0;
    logic [31:0]       Brk_pc = 32'h10;
    logic [ADDR_W-1:0] Mem_addr;
    logic [31:0]       Mem_data;
    logic [31:0]       PC;
    logic [31:0]       Inst_code;
    logic              Inst_valid;
    logic              Halted;

    logic [31:0] rom [NWORDS];
    logic [31:0] rom_pipe [MEM_LAT];

    fetch_t exp_q [$];
    int     checks = 0;
    int     errors = 0;

    // Reference model state
    int          cyc_n     = 0;
    int          idle_from = 0;
    int          run_len   = 0;
    logic [31:0] m_pc      = 32'd0;
    bit          m_pending = 1'b0;
    bit          m_step_q  = 1'b0;
    bit          m_halted  = 1'b0;
    bit          rst_prev  = 1'b0;
    logic        prev_valid = 1'b0;

    fetch_sequencer #(
        .ADDR_W (ADDR_W),
        .MEM_LAT(MEM_LAT),
        .RUN_DIV(RUN_DIV)
    ) dut (
        .Clk       (Clk),
        .Rst       (Rst),
        .Step      (Step),
        .Run       (Run),
        .Brk_pc    (Brk_pc),
        .Mem_addr  (Mem_addr),
        .Mem_data  (Mem_data),
        .PC        (PC),
        .Inst_code (Inst_code),
        .Inst_valid(Inst_valid),
        .Halted    (Halted)
    );

    // System clock.
    always #5 Clk = ~Clk;

    // ROM with MEM_LAT cycles of read latency.
    always @(posedge Clk) begin
        rom_pipe[0] <= rom[Mem_addr];
        for (int i = 1; i < MEM_LAT; i++) begin
            rom_pipe[i] <= rom_pipe[i-1];
        end
    end
    assign Mem_data = rom_pipe[MEM_LAT-1];

    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h at %0t",
                     name, actual, expected, $time);
        end
    endtask

    task automatic applyStimulus(input logic step, input logic run,
                                 input logic rst, input int cycles);
        Step = step;
        Run  = run;
        Rst  = rst;
        repeat (cycles) begin
            @(posedge Clk);
            #1;
        end
    endtask

    // Reference model: each cycle predicts PC, Inst_valid and Halted from
    // when the last advance happened, and queues the fetch each advance owes.
    always @(negedge Clk) begin : model
        bit idle;
        bit edge_s;
        bit tick;
        bit adv;
        bit brk;
        if (Rst) begin
            if (rst_prev) begin
                checkOutput("reset_pc", PC, 32'd0);
                checkOutput("reset_code", Inst_code, 32'd0);
                checkOutput("reset_valid", 32'(Inst_valid), 32'd0);
                checkOutput("reset_halted", 32'(Halted), 32'd0);
            end
            rst_prev  = 1'b1;
            cyc_n     = 0;
            idle_from = 1 + MEM_LAT;
            run_len   = 0;
            m_pc      = 32'd0;
            m_pending = 1'b0;
            m_step_q  = 1'b0;
            m_halted  = 1'b0;
            exp_q.delete();
            exp_q.push_back('{pc: 32'd0, code: rom[0]});
        end else begin
            rst_prev = 1'b0;
            idle     = (cyc_n >= idle_from);
            checkOutput("pc", PC, m_pc);
            checkOutput("mem_addr", 32'(Mem_addr), m_pc >> 2);
            checkOutput("inst_valid", 32'(Inst_valid), 32'(idle));
            checkOutput("halted", 32'(Halted), 32'(m_halted));

            edge_s   = Step && !m_step_q;
            m_step_q = Step;
            run_len  = Run ? run_len + 1 : 0;
            tick     = Run && ((run_len % RUN_DIV) == 0);
            brk      = 1'b0;
`ifdef FETCH_BRK_EN
            brk = Run && idle && (m_pc == Brk_pc);
`endif
            adv = 1'b0;
            if (Run) begin
                m_pending = 1'b0;
                adv = idle && tick && !m_halted && !brk;
            end else if (idle && (edge_s || m_pending)) begin
                adv = 1'b1;
                m_pending = 1'b0;
            end else if (!idle && edge_s) begin
                m_pending = 1'b1;
            end

            if (!Run) begin
                m_halted = 1'b0;
            end else if (brk) begin
                m_halted = 1'b1;
            end

            if (adv) begin
                m_pc      = (m_pc + 32'd4) % PC_SPAN;
                idle_from = cyc_n + 2 + MEM_LAT;
                exp_q.push_back('{pc: m_pc, code: rom[m_pc[ADDR_W+1:2]]});
            end
            cyc_n++;
        end
    end

    // Scoreboard monitor: every rising Inst_valid retires the oldest fetch.
    always @(negedge Clk) begin : monitor
        fetch_t e;
        if (Rst) begin
            prev_valid = Inst_valid;
        end else begin
            if (Inst_valid && !prev_valid) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("[TB] FAIL fetch_unexpected: got PC 0x%08h, expected no fetch at %0t",
                             PC, $time);
                end else begin
                    e = exp_q.pop_front();
                    checkOutput("fetch_pc", PC, e.pc);
                    checkOutput("fetch_code", Inst_code, e.code);
                end
            end
            prev_valid = Inst_valid;
        end
    end

    // Directed scenarios followed by a randomized soak.
    initial begin
        bit run_mode;
        rom[0] = 32'h2001_0005;
        rom[1] = 32'h8C22_0000;
        for (int i = 2; i < NWORDS; i++) begin
            rom[i] = $urandom;
        end

        applyStimulus(1'b0, 1'b0, 1'b1, 3);
        applyStimulus(1'b0, 1'b0, 1'b0, 6);

        applyStimulus(1'b1, 1'b0, 1'b0, 1);
        applyStimulus(1'b0, 1'b0, 1'b0, 6);

        repeat (63) begin
            applyStimulus(1'b1, 1'b0, 1'b0, 1);
            applyStimulus(1'b0, 1'b0, 1'b0, 3);
        end
        applyStimulus(1'b0, 1'b0, 1'b0, 4);

        applyStimulus(1'b0, 1'b0, 1'b1, 1);
        for (int i = 0; i < 6; i++) begin
            applyStimulus(1'(i % 2 == 0), 1'b0, 1'b0, 1);
        end
        applyStimulus(1'b0, 1'b0, 1'b0, 8);

        for (int i = 0; i < 48; i++) begin
            applyStimulus(1'($urandom_range(0, 1)), 1'b1, 1'b0, 1);
        end
        applyStimulus(1'b0, 1'b0, 1'b0, 10);
        applyStimulus(1'b1, 1'b0, 1'b0, 1);
        applyStimulus(1'b0, 1'b0, 1'b0, 6);

        applyStimulus(1'b1, 1'b0, 1'b0, 1);
        applyStimulus(1'b0, 1'b0, 1'b0, 1);
        applyStimulus(1'b0, 1'b0, 1'b1, 1);
        applyStimulus(1'b0, 1'b0, 1'b0, 5);

        run_mode = 1'b0;
        for (int i = 0; i < 1500; i++) begin
            if ($urandom_range(0, 39) == 0) begin
                run_mode = !run_mode;
            end
            applyStimulus(1'($urandom_range(0, 1)), run_mode,
                          1'($urandom_range(0, 299) == 0),
                          int'($urandom_range(1, 3)));
        end

        applyStimulus(1'b0, 1'b0, 1'b0, 12);
        checkOutput("scoreboard_drain", 32'(exp_q.size()), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
